serial_word_adder: RTL and testbench

- Word-level front/back end for the bit-serial addition stream.
- Accepts two parallel W-bit operands over a valid/ready handshake and serializes them LSB-first into an internal serial full-adder cell. That cell uses ^, &, |, ~ only.
- Collects the serial sum bits back into a parallel W-bit result, then presents it with the final carry over a second valid/ready handshake.
- Supports add and subtract (two's complement: b inverted, carry-in 1).

---
 rtl/serial_adder_pkg.sv | 29 ++
 rtl/serial_full_adder_bit.sv | 29 ++
 rtl/serial_word_adder.sv | 125 ++++++++++++
 tb/tb_serial_word_adder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg
//
// Shared definitions for the bit-serial word adder:
//   - sa_state_t     : control states of the word-level sequencer
//   - DEFAULT_WIDTH  : default operand/result width
//   - cntWidth()     : width of the bit counter needed for a given word width
// ---------------------------------------------------------------------------
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_t;

    // Number of bits needed to count 0..w-1, never less than one bit.
    function automatic int cntWidth(input int w);
        int bits;
        bits = $clog2(w);
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/serial_full_adder_bit.sv
// ---------------------------------------------------------------------------
// serial_full_adder_bit
//
// One-bit full adder cell used by the serial word adder. Purely
// combinational and built from XOR/AND/OR only, so the datapath contains
// no arithmetic operators.
//
// Ports:
//   a, b  in   operand bits
//   cin   in   carry in
//   s     out  sum bit
//   cout  out  carry out
// ---------------------------------------------------------------------------
module serial_full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic halfSum;

    // The half-sum both forms the sum and decides whether carry propagates.
    assign halfSum = a ^ b;
    assign s       = halfSum ^ cin;
    assign cout    = (a & b) | (cin & halfSum);

endmodule

// File: rtl/serial_word_adder.sv
// ---------------------------------------------------------------------------
// serial_word_adder
//
// Word-level front/back end around a bit-serial full adder. A pair of W-bit
// operands is accepted over a valid/ready handshake, shifted LSB-first
// through a single full-adder cell over W clock edges, and the collected
// sum is presented with the final carry over a second valid/ready
// handshake. Subtraction is A + ~B + 1 (B inverted at load, carry seeded 1).
//
// Ports:
//   clk        in   clock, rising-edge
//   rst        in   synchronous active-high reset
//   in_valid   in   operand pair offered
//   in_ready   out  operands can be accepted this cycle
//   in_a       in   operand A (W bits)
//   in_b       in   operand B (W bits)
//   in_sub     in   0 = A+B, 1 = A-B, sampled with the operands
//   out_valid  out  result available
//   out_ready  in   consumer accepts result
//   out_sum    out  result word (W bits), registered
//   out_carry  out  carry out of MSB (1 = no borrow on subtract), registered
// ---------------------------------------------------------------------------
module serial_word_adder
    import serial_adder_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_sum,
    output logic         out_carry
);

    localparam int            CW   = cntWidth(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    sa_state_t     state_q;
    logic [W-1:0]  aSh_q;
    logic [W-1:0]  bSh_q;
    logic [W-1:0]  res_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;

    logic sumBit;
    logic carry_d;
    logic accept;

    // Serial cell always looks at the current LSBs and the stored carry.
    serial_full_adder_bit u_fullAdder (
        .a    (aSh_q[0]),
        .b    (bSh_q[0]),
        .cin  (carry_q),
        .s    (sumBit),
        .cout (carry_d)
    );

    // A finished result can be handed off and replaced in the same edge,
    // hence the out_ready term when sitting in DONE.
    assign in_ready  = ~rst & ((state_q == IDLE) |
                               ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = ~rst & (state_q == DONE);
    assign out_sum   = res_q;
    assign out_carry = carry_q;

    // Sequencer and datapath. Loading inverts B and seeds the carry with
    // in_sub so subtraction falls out of the same adder cell. The result
    // register fills from the MSB end, so after W shifts the first sum bit
    // has reached bit 0. The carry of the last bit stays in carry_q and is
    // presented directly as out_carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            aSh_q   <= '0;
            bSh_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        aSh_q   <= in_a;
                        bSh_q   <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    aSh_q   <= aSh_q >> 1;
                    bSh_q   <= bSh_q >> 1;
                    res_q   <= {sumBit, res_q[W-1:1]};
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (accept) begin
                        aSh_q   <= in_a;
                        bSh_q   <= in_sub ? ~in_b : in_b;
                        carry_q <= in_sub;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end else if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_word_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_word_adder
//
// Self-checking bench for serial_word_adder (W = 8): a table of directed
// vectors, hand-written backpressure and mid-operation reset sequences,
// and a randomized stream compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_serial_word_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_carry;

    int vecCount  = 0;
    int missCount = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] expSum;
        logic       expCarry;
    } vec_t;

    vec_t vecs[5];

    serial_word_adder #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic. Bit 8 is the carry out, which for
    // a subtract is 1 exactly when no borrow occurred.
    function automatic logic [8:0] refModel(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic sub);
        int total;
        if (sub) begin
            total = int'(a) + (255 - int'(b)) + 1;
        end else begin
            total = int'(a) + int'(b);
        end
        return 9'(total);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Offer an operand pair on a falling edge and hold it through the
    // accepting rising edge; returns on the falling edge after the accept.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic sub);
        @(negedge clk);
        in_a     = a;
        in_b     = b;
        in_sub   = sub;
        in_valid = 1'b1;
        #1;
        checkOutput("in_ready at offer", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_sub   = 1'($urandom_range(0, 1));
    endtask

    // Count rising edges from the accept edge until out_valid, bounded.
    task automatic waitResult(output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (out_valid) begin
                break;
            end
        end
        checkOutput("out_valid within budget", out_valid, 1);
    endtask

    task automatic runOp(input string name, input logic [7:0] a,
                         input logic [7:0] b, input logic sub,
                         input logic [7:0] expSum, input logic expCarry);
        int edges;
        out_ready = 1'b1;
        applyStimulus(a, b, sub);
        waitResult(edges);
        checkOutput({name, " latency"}, edges, W);
        checkOutput({name, " sum"}, out_sum, expSum);
        checkOutput({name, " carry"}, out_carry, expCarry);
        @(posedge clk);
        #1;
        checkOutput({name, " out_valid drops after pop"}, out_valid, 0);
    endtask

    initial begin
        int edges;
        int issued;
        int received;
        logic holding;
        logic [8:0] expQ[$];
        logic [8:0] expVal;

        vecs[0] = '{a: 8'h5A, b: 8'h33, sub: 1'b0, expSum: 8'h8D, expCarry: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, expSum: 8'h00, expCarry: 1'b1};
        vecs[2] = '{a: 8'hFF, b: 8'hFF, sub: 1'b0, expSum: 8'hFE, expCarry: 1'b1};
        vecs[3] = '{a: 8'h10, b: 8'h01, sub: 1'b1, expSum: 8'h0F, expCarry: 1'b1};
        vecs[4] = '{a: 8'h00, b: 8'h01, sub: 1'b1, expSum: 8'hFF, expCarry: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_sub    = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_sum", out_sum, 0);
        checkOutput("reset out_carry", out_carry, 0);
        checkOutput("reset in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        checkOutput("in_ready after reset", in_ready, 1);

        // Directed table
        foreach (vecs[i]) begin
            runOp($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                  vecs[i].expSum, vecs[i].expCarry);
        end

        // Backpressure: hold the result for 5 cycles, then pop and accept
        // new operands in the same edge.
        out_ready = 1'b0;
        applyStimulus(8'h5A, 8'h33, 1'b0);
        waitResult(edges);
        checkOutput("stall first latency", edges, W);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("stall%0d out_valid", i), out_valid, 1);
            checkOutput($sformatf("stall%0d out_sum", i), out_sum, 8'h8D);
            checkOutput($sformatf("stall%0d out_carry", i), out_carry, 0);
            checkOutput($sformatf("stall%0d in_ready", i), in_ready, 0);
        end
        @(negedge clk);
        in_a      = 8'h01;
        in_b      = 8'h02;
        in_sub    = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        checkOutput("back-to-back in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(edges);
        checkOutput("back-to-back latency", edges, W);
        checkOutput("back-to-back sum", out_sum, 8'h03);
        checkOutput("back-to-back carry", out_carry, 0);
        @(posedge clk);
        #1;
        checkOutput("back-to-back pop", out_valid, 0);

        // Reset during SHIFT: rst sampled on edge 4 after the accept edge.
        out_ready = 1'b1;
        applyStimulus(8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid-reset out_valid", out_valid, 0);
        checkOutput("mid-reset out_sum", out_sum, 0);
        checkOutput("mid-reset out_carry", out_carry, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("post-reset in_ready", in_ready, 1);
        runOp("post-reset op", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0);

        // Randomized stream with random stalls on both sides.
        issued   = 0;
        received = 0;
        holding  = 1'b0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20000 && received < 200; cyc++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!holding) begin
                if (issued < 200 && $urandom_range(0, 4) != 0) begin
                    in_a     = 8'($urandom);
                    in_b     = 8'($urandom);
                    in_sub   = 1'($urandom_range(0, 1));
                    in_valid = 1'b1;
                    holding  = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            #1;
            if (out_valid && out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("random result without request", expQ.size(), 1);
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput($sformatf("random result %0d", received),
                                {out_carry, out_sum}, expVal);
                    received++;
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(in_a, in_b, in_sub));
                issued++;
                holding = 1'b0;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("random results received", received, 200);
        checkOutput("random results outstanding", expQ.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
